// File: rtl/interrupt_controller.sv
// Four-source interrupt controller with a fixed lowest-index-first priority.
// It captures requests into pending bits, signals the CPU and waits for intAck and eoi.
module interrupt_controller #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  srcReq,
    input  logic [63:0] srcData,
    input  logic        maskWe,
    input  logic [3:0]  maskIn,
    input  logic        intAck,
    input  logic        eoi,
    output logic        interruptSignal,
    output logic [3:0]  interruptIndex,
    output logic [15:0] data,
    output logic [3:0]  pending,
    output logic        busy,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_mask;
    logic [3:0]  r_pending;
    logic [15:0] r_latch [4];
    logic [15:0] r_cnt;
    logic [3:0]  r_index;
    logic [15:0] r_data;
    logic        r_irq_n;
    logic        r_busy;

    logic [3:0]  w_cap;
    logic [3:0]  w_keep;
    logic [3:0]  w_ack_clr;
    logic [3:0]  w_pend_next;
    logic [1:0]  w_pri_idx;
    logic        w_mask_drop;
    logic        w_ack;

    always_comb begin
        w_cap       = ~srcReq & r_mask;
        w_keep      = maskWe ? maskIn : 4'hF;
        w_mask_drop = (r_state == ST_REQ) && maskWe && !maskIn[r_index[1:0]];
        w_ack       = (r_state == ST_REQ) && intAck && !w_mask_drop;
        w_ack_clr   = w_ack ? (4'b0001 << r_index[1:0]) : 4'b0000;
        // Captures are OR-ed in last so a same-edge set beats any clear.
        w_pend_next = (r_pending & w_keep & ~w_ack_clr) | w_cap;
        w_pri_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pri_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mask    <= 4'b0001;
            r_pending <= 4'b0000;
            r_cnt     <= 16'd0;
            r_index   <= 4'd0;
            r_data    <= 16'd0;
            r_irq_n   <= 1'b1;
            r_busy    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_latch[i] <= 16'd0;
            end
        end else begin
            r_pending <= w_pend_next;
            if (maskWe) begin
                r_mask <= maskIn;
            end
            for (int i = 0; i < 4; i++) begin
                if (w_cap[i]) begin
                    r_latch[i] <= srcData[16*i +: 16];
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_pending != 4'b0000) begin
                        r_state <= ST_REQ;
                        r_index <= {2'b00, w_pri_idx};
                        r_data  <= r_latch[w_pri_idx];
                        r_cnt   <= 16'd0;
                        r_irq_n <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (w_mask_drop) begin
                        r_state <= ST_IDLE;
                        r_irq_n <= 1'b1;
                    end else if (w_ack) begin
                        r_state <= ST_SERVICE;
                        r_irq_n <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= ST_IDLE;
                        r_irq_n <= 1'b1;
                    end else if (r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq_n <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign interruptSignal = r_irq_n;
    assign interruptIndex  = r_index;
    assign data            = r_data;
    assign pending         = r_pending;
    assign busy            = r_busy;
    assign dbgState        = r_state;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with ACK_TIMEOUT=4.
// Each scenario task drives its own vectors and checks against hand-computed values.
module tb_interrupt_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  srcReq;
    logic [63:0] srcData;
    logic        maskWe;
    logic [3:0]  maskIn;
    logic        intAck;
    logic        eoi;
    logic        interruptSignal;
    logic [3:0]  interruptIndex;
    logic [15:0] data;
    logic [3:0]  pending;
    logic        busy;
    logic [1:0]  dbgState;

    int n_vec;
    int n_err;

    interrupt_controller #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .srcReq(srcReq), .srcData(srcData),
        .maskWe(maskWe), .maskIn(maskIn), .intAck(intAck), .eoi(eoi),
        .interruptSignal(interruptSignal), .interruptIndex(interruptIndex),
        .data(data), .pending(pending), .busy(busy), .dbgState(dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; srcReq = 4'hF; srcData = 64'd0; maskWe = 1'b0;
        maskIn = 4'h0; intAck = 1'b0; eoi = 1'b0;
        #2;
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL reset_irq got %b exp 1", interruptSignal); end
        n_vec++; if (interruptIndex !== 4'd0) begin n_err++; $display("FAIL reset_index got %h exp 0", interruptIndex); end
        n_vec++; if (data !== 16'd0) begin n_err++; $display("FAIL reset_data got %h exp 0", data); end
        n_vec++; if (pending !== 4'd0) begin n_err++; $display("FAIL reset_pending got %b exp 0000", pending); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_keyboard();
        srcReq = 4'b1110; srcData = 64'h0000_0000_0000_0041;
        tick();
        srcReq = 4'hF;
        n_vec++; if (pending !== 4'b0001) begin n_err++; $display("FAIL kbd_pending got %b exp 0001", pending); end
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL kbd_irq_early got %b exp 1", interruptSignal); end
        tick();
        n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL kbd_irq got %b exp 0", interruptSignal); end
        n_vec++; if (interruptIndex !== 4'd0) begin n_err++; $display("FAIL kbd_index got %h exp 0", interruptIndex); end
        n_vec++; if (data !== 16'h0041) begin n_err++; $display("FAIL kbd_data got %h exp 0041", data); end
        intAck = 1'b1;
        tick();
        intAck = 1'b0;
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL kbd_ack_irq got %b exp 1", interruptSignal); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL kbd_ack_busy got %b exp 1", busy); end
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL kbd_ack_pending got %b exp 0000", pending); end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL kbd_eoi_busy got %b exp 0", busy); end
    endtask

    task automatic test_ignored();
        intAck = 1'b1;
        tick();
        intAck = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_ack_busy got %b exp 0", busy); end
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL ign_ack_irq got %b exp 1", interruptSignal); end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL ign_eoi_irq got %b exp 1", interruptSignal); end
    endtask

    task automatic test_priority();
        maskWe = 1'b1; maskIn = 4'b1111;
        tick();
        maskWe = 1'b0;
        srcReq = 4'b1011; srcData = 64'h0000_2222_0000_0000;
        tick();
        srcReq = 4'hF;
        n_vec++; if (pending !== 4'b0100) begin n_err++; $display("FAIL pri_pending2 got %b exp 0100", pending); end
        tick();
        n_vec++; if (interruptIndex !== 4'd2) begin n_err++; $display("FAIL pri_index2 got %h exp 2", interruptIndex); end
        srcReq = 4'b1101; srcData = 64'h0000_0000_1111_0000;
        tick();
        srcReq = 4'hF;
        n_vec++; if (pending !== 4'b0110) begin n_err++; $display("FAIL pri_pending21 got %b exp 0110", pending); end
        n_vec++; if (interruptIndex !== 4'd2) begin n_err++; $display("FAIL pri_nopreempt_index got %h exp 2", interruptIndex); end
        n_vec++; if (data !== 16'h2222) begin n_err++; $display("FAIL pri_nopreempt_data got %h exp 2222", data); end
        intAck = 1'b1;
        tick();
        intAck = 1'b0;
        n_vec++; if (pending !== 4'b0010) begin n_err++; $display("FAIL pri_ack_pending got %b exp 0010", pending); end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL pri_irq1 got %b exp 0", interruptSignal); end
        n_vec++; if (interruptIndex !== 4'd1) begin n_err++; $display("FAIL pri_index1 got %h exp 1", interruptIndex); end
        n_vec++; if (data !== 16'h1111) begin n_err++; $display("FAIL pri_data1 got %h exp 1111", data); end
        intAck = 1'b1;
        tick();
        intAck = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL pri_end_pending got %b exp 0000", pending); end
    endtask

    task automatic test_masking();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        srcReq = 4'b0111; srcData = 64'h3333_0000_0000_0000;
        tick();
        srcReq = 4'hF;
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL mask_discard_pending got %b exp 0000", pending); end
        tick();
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL mask_discard_irq got %b exp 1", interruptSignal); end
        srcReq = 4'b1110; srcData = 64'h0000_0000_0000_0005;
        tick();
        srcReq = 4'hF;
        tick();
        n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL mask_src0_irq got %b exp 0", interruptSignal); end
        maskWe = 1'b1; maskIn = 4'b1001;
        tick();
        maskWe = 1'b0;
        srcReq = 4'b0111; srcData = 64'h3333_0000_0000_0000;
        tick();
        srcReq = 4'hF;
        n_vec++; if (pending !== 4'b1001) begin n_err++; $display("FAIL mask_en3_pending got %b exp 1001", pending); end
        intAck = 1'b1;
        tick();
        intAck = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        n_vec++; if (interruptIndex !== 4'd3) begin n_err++; $display("FAIL mask_index3 got %h exp 3", interruptIndex); end
        n_vec++; if (data !== 16'h3333) begin n_err++; $display("FAIL mask_data3 got %h exp 3333", data); end
        maskWe = 1'b1; maskIn = 4'b0001;
        tick();
        maskWe = 1'b0;
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL mask_drop_irq got %b exp 1", interruptSignal); end
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL mask_drop_pending got %b exp 0000", pending); end
        tick();
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL mask_drop_idle got %b exp 1", interruptSignal); end
    endtask

    task automatic test_timeout();
        srcReq = 4'b1110; srcData = 64'h0000_0000_0000_0AAA;
        tick();
        srcReq = 4'hF;
        tick();
        n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL to_low0 got %b exp 0", interruptSignal); end
        for (int k = 1; k < 4; k++) begin
            tick();
            n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL to_low%0d got %b exp 0", k, interruptSignal); end
        end
        tick();
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL to_release got %b exp 1", interruptSignal); end
        n_vec++; if (pending !== 4'b0001) begin n_err++; $display("FAIL to_retained got %b exp 0001", pending); end
        tick();
        n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL to_resignal got %b exp 0", interruptSignal); end
        n_vec++; if (data !== 16'h0AAA) begin n_err++; $display("FAIL to_resignal_data got %h exp 0aaa", data); end
    endtask

    task automatic test_simultaneous();
        srcReq = 4'b1110; srcData = 64'h0000_0000_0000_0BBB; intAck = 1'b1;
        tick();
        srcReq = 4'hF; intAck = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sim_busy got %b exp 1", busy); end
        n_vec++; if (pending !== 4'b0001) begin n_err++; $display("FAIL sim_setwins got %b exp 0001", pending); end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL sim_resignal got %b exp 0", interruptSignal); end
        n_vec++; if (data !== 16'h0BBB) begin n_err++; $display("FAIL sim_newdata got %h exp 0bbb", data); end
        intAck = 1'b1;
        tick();
        intAck = 1'b0;
    endtask

    task automatic test_async_reset();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ar_in_service got %b exp 1", busy); end
        srcReq = 4'b1110; srcData = 64'h0000_0000_0000_0CCC;
        tick();
        srcReq = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got %b exp 0", busy); end
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL ar_pending got %b exp 0000", pending); end
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL ar_irq got %b exp 1", interruptSignal); end
        n_vec++; if (interruptIndex !== 4'd0) begin n_err++; $display("FAIL ar_index got %h exp 0", interruptIndex); end
        n_vec++; if (data !== 16'd0) begin n_err++; $display("FAIL ar_data got %h exp 0", data); end
        #2;
        rst = 1'b0;
        tick();
        tick();
        n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL ar_lost got %b exp 1", interruptSignal); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_keyboard();
        test_ignored();
        test_priority();
        test_masking();
        test_timeout();
        test_simultaneous();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
